scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Sequencer that loads the accelerator's serial configuration scan chain from a word-wide host interface.
- Accepts CHAIN_LEN bits as WORD_W-bit words over a valid/ready handshake and serializes them onto si, driving se.
- Counts shifts exactly and signals completion, so the mapping registers (H, R, E, C, M, N, U, V, n, e, p, q, r, t, X) are valid when done pulses.
- Sits between the host/config bus and the scan chain instance.

Parameters:
- CHAIN_LEN, 71, total scan flops in the chain (sum of all field widths)
- WORD_W, 16, host word width
- CNT_W, $clog2(CHAIN_LEN+1), total-bit counter width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  begin a configuration (sampled in IDLE only)
- abort  in  1  synchronous abort, any state
- cfg_data  in  WORD_W  configuration word, stream bits LSB first
- cfg_valid  in  1  host word valid
- cfg_ready  out  1  controller accepts word
- se  out  1  scan enable to chain (registered)
- si  out  1  scan data to chain (registered)
- so  in  1  scan data out of chain
- busy  out  1  configuration in progress
- done  out  1  one-cycle pulse, chain fully loaded

Behaviour:
- Reset (async): state IDLE; cfg_ready=0, se=0, si=0, busy=0, done=0; counters and shift register cleared.
- Stream order: stream bit k = word floor(k/WORD_W), bit k mod WORD_W. Bit 0 is shifted first and ends in the flop farthest from si (X). Bit CHAIN_LEN-1 ends in the flop nearest si (H MSB side).
- Word count: ceil(CHAIN_LEN/WORD_W), which is 5 at defaults. The last word uses its low CHAIN_LEN mod WORD_W bits (7); the upper bits are ignored.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - start=1 -> LOAD; busy=1 from the next cycle.
  - start is ignored in every other state.
- LOAD:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready: latch the word and set word_bits = min(WORD_W, remaining) -> SHIFT.
  - se=0 while in LOAD; the chain holds its contents during host stalls.
- SHIFT:
  - Each cycle: se=1, si=shreg[0]; shreg shifts right; word_bits and remaining decrement.
  - When word_bits hits 0: remaining>0 -> LOAD, remaining==0 -> DONE.
  - se/si are registered, so the chain sees each bit the cycle after the shifter produces it.
  - se is high for exactly CHAIN_LEN cycles per configuration.
- DONE:
  - Entered after the final se-high cycle; done=1 for one cycle.
  - busy=0 and state IDLE on the next cycle.
- Latency with no host stalls: CHAIN_LEN + words + 2 cycles from start to done.
- abort=1 in any state: next cycle goes to IDLE with se=0, cfg_ready=0, busy=0, no done. The chain is left partially loaded and is invalid.
- abort and start together in IDLE: abort wins, state stays IDLE.
- Reset mid-shift behaves like abort but is asynchronous.
- No other output changes while in IDLE.

Optional Feature:
- Macro: SCAN_CHAIN_READBACK_EN.
- With the macro, the block adds ports rb_data (out, WORD_W), rb_valid (out, 1) and rb_ready (in, 1).
  - so is sampled on every se-high cycle into a readback shifter in the same bit order as the input stream, so the previous chain contents come out as words.
  - After each WORD_W shifts, or after the final partial word (zero-extended), rb_valid=1 with rb_data.
  - While rb_valid && !rb_ready: no new LOAD and no SHIFT (se=0), i.e. backpressure stalls the scan.
  - rb_valid clears on handshake, abort or reset.
  - DONE is not entered until the last readback word is accepted.
- Without the macro, these ports and that logic are absent, and so is ignored.

Test Plan:
- Five words 0xFFFF ×5 with the chain instance attached -> se high exactly 71 cycles, done once; H=0xFF, R=0xF, E=0x3F, C=M=0x3FF, X=1, all fields all-ones.
- Words 0x0001, 0, 0, 0, 0 -> X=1, every other field 0; done asserted; busy falls the cycle after done.
- Last word 0xFF80, others 0 -> all fields 0 (ignored upper bits never shifted); se-high count still 71.
- Host holds cfg_valid low 10 cycles before word 2 -> se=0 for those cycles; final field values identical to the unstalled run; total cycles +10.
- abort after 30 se-high cycles -> no done, busy=0 and se=0 the next cycle. A following start with a full load then completes normally with 71 shifts.
- With SCAN_CHAIN_READBACK_EN:
  - Load pattern A (0xA5A5 ×5), then load B -> the readback during B returns A's words. Last word = 0x0025 (A's low 7 bits, zero-extended).
  - rb_ready held low 5 cycles -> se stalls 5 cycles.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// Loads the accelerator's serial configuration scan chain from word-wide host data.
// Define SCAN_CHAIN_READBACK_EN to capture the previous chain contents from so as readback words.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 71,
  parameter int WORD_W    = 16,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              se,
  output logic              si,
  input  logic              so,
  output logic              busy,
  output logic              done
`ifdef SCAN_CHAIN_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready
`endif
);

  localparam int WB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t            state, next_state;
  logic [WORD_W-1:0] shreg;
  logic [WB_W-1:0]   word_bits;
  logic [CNT_W-1:0]  remaining;
  logic              se_q, si_q, busy_q, done_q;
  logic              load_word, shift_now, cfg_ready_c;
  logic              stall, done_ok;

`ifdef SCAN_CHAIN_READBACK_EN
  logic [WORD_W-1:0] rb_shreg, rb_data_q;
  logic [WB_W-1:0]   rb_cnt;
  logic [CNT_W-1:0]  rb_left;
  logic              rb_valid_q;

  // An unaccepted readback word freezes the scan; completion waits for the last word to drain.
  assign stall   = rb_valid_q && !rb_ready;
  assign done_ok = !se_q && (!rb_valid_q || rb_ready);
  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_so;
  assign unused_so = so;
  assign stall     = 1'b0;
  assign done_ok   = 1'b1;
`endif

  assign cfg_ready = cfg_ready_c;
  assign se        = se_q;
  assign si        = si_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state decode; abort overrides everything, including a start seen in IDLE.
  always_comb begin
    next_state  = state;
    load_word   = 1'b0;
    shift_now   = 1'b0;
    cfg_ready_c = 1'b0;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (start) next_state = LOAD;
        LOAD: begin
          cfg_ready_c = !stall;
          if (cfg_valid && !stall) begin
            load_word  = 1'b1;
            next_state = SHIFT;
          end
        end
        SHIFT: begin
          if (!stall) begin
            shift_now = 1'b1;
            if (word_bits == WB_W'(1))
              next_state = (remaining == CNT_W'(1)) ? DONE : LOAD;
          end
        end
        DONE: if (done_ok) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      word_bits <= '0;
      remaining <= '0;
      se_q      <= 1'b0;
      si_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state  <= next_state;
      se_q   <= shift_now;
      done_q <= (state == DONE) && (next_state == IDLE) && !abort;
      busy_q <= (next_state != IDLE) || ((state == DONE) && !abort);
      if (state == IDLE && next_state == LOAD)
        remaining <= CNT_W'(CHAIN_LEN);
      if (load_word) begin
        shreg <= cfg_data;
        if (int'(remaining) >= WORD_W)
          word_bits <= WB_W'(WORD_W);
        else
          word_bits <= WB_W'(remaining);
      end
      if (shift_now) begin
        si_q      <= shreg[0];
        shreg     <= shreg >> 1;
        word_bits <= word_bits - WB_W'(1);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

`ifdef SCAN_CHAIN_READBACK_EN
  // so is sampled while se is high, i.e. on the same edge the chain shifts that bit out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rb_shreg   <= '0;
      rb_data_q  <= '0;
      rb_cnt     <= '0;
      rb_left    <= '0;
      rb_valid_q <= 1'b0;
    end else if (abort) begin
      rb_shreg   <= '0;
      rb_cnt     <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      if (state == IDLE && next_state == LOAD) begin
        rb_left  <= CNT_W'(CHAIN_LEN);
        rb_cnt   <= '0;
        rb_shreg <= '0;
      end
      if (rb_valid_q && rb_ready)
        rb_valid_q <= 1'b0;
      if (se_q) begin
        rb_left <= rb_left - CNT_W'(1);
        if (rb_cnt == WB_W'(WORD_W - 1) || rb_left == CNT_W'(1)) begin
          rb_data_q  <= rb_shreg | (WORD_W'(so) << rb_cnt);
          rb_valid_q <= 1'b1;
          rb_shreg   <= '0;
          rb_cnt     <= '0;
        end else begin
          rb_shreg <= rb_shreg | (WORD_W'(so) << rb_cnt);
          rb_cnt   <= rb_cnt + WB_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl with a behavioural 71-flop scan chain attached.
// Readback checks are compiled in when SCAN_CHAIN_READBACK_EN is defined.
module tb_scan_chain_ctrl;

  localparam int CHAIN_LEN = 71;
  localparam int WORD_W    = 16;
  localparam int WORDS     = 5;
`ifdef SCAN_CHAIN_READBACK_EN
  localparam int RB_EXTRA = 1;
`else
  localparam int RB_EXTRA = 0;
`endif
  localparam int BASE_LAT = CHAIN_LEN + WORDS + 2 + RB_EXTRA;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [WORD_W-1:0] cfg_data = '0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready, se, si, so, busy, done;
  logic [CHAIN_LEN-1:0] chain = '0;

  int checks = 0;
  int errors = 0;
  int se_count = 0;
  int done_count = 0;
  int cyc = 0;
  int t_start = 0;
  int t_done = 0;
  logic si_q[$];

`ifdef SCAN_CHAIN_READBACK_EN
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready = 1'b1;
  logic [WORD_W-1:0] rb_q[$];
  int                rb_stall_left = 0;
`endif

  scan_chain_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .se        (se),
    .si        (si),
    .so        (so),
    .busy      (busy),
    .done      (done)
`ifdef SCAN_CHAIN_READBACK_EN
    ,
    .rb_data   (rb_data),
    .rb_valid  (rb_valid),
    .rb_ready  (rb_ready)
`endif
  );

  always #5 clk = ~clk;

  // Chain model: si enters the top flop (H side), so leaves from flop 0 (X).
  assign so = chain[0];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (se) chain <= {si, chain[CHAIN_LEN-1:1]};
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Output monitor: scoreboard pops run a couple of ns after the falling edge.
  always @(negedge clk) begin
    #2;
    if (se) begin
      se_count++;
      checkOutput("si_queue_nonempty", 128'(si_q.size() != 0), 128'(1));
      if (si_q.size() != 0) checkOutput("si_bit", 128'(si), 128'(si_q.pop_front()));
    end
    if (done) begin
      done_count++;
      t_done = cyc;
    end
`ifdef SCAN_CHAIN_READBACK_EN
    if (rb_valid && rb_ready) begin
      checkOutput("rb_queue_nonempty", 128'(rb_q.size() != 0), 128'(1));
      if (rb_q.size() != 0) checkOutput("rb_word", 128'(rb_data), 128'(rb_q.pop_front()));
    end
`endif
  end

  task automatic tick();
    @(negedge clk);
`ifdef SCAN_CHAIN_READBACK_EN
    if (rb_stall_left > 0 && rb_valid) begin
      rb_ready = 1'b0;
      rb_stall_left--;
    end else begin
      rb_ready = 1'b1;
    end
`endif
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start   = 1'b1;
    t_start = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive_word(input logic [WORD_W-1:0] w, input int nbits, input int pre_stall);
    int n = 0;
    tick();
    while (!cfg_ready && n < 300) begin
      tick();
      n++;
    end
    checkOutput("cfg_ready", 128'(cfg_ready), 128'(1));
    repeat (pre_stall) tick();
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < nbits; i++) si_q.push_back(w[i]);
    @(posedge clk);
    #1 cfg_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [79:0] words, input int stall_word, input int stall_cycles,
                               input int exp_lat);
    int base_se   = se_count;
    int base_done = done_count;
    int n = 0;
`ifdef SCAN_CHAIN_READBACK_EN
    logic [79:0] prev = {9'b0, chain};
    for (int j = 0; j < WORDS; j++) rb_q.push_back(prev[16*j +: 16]);
`endif
    pulse_start();
    for (int i = 0; i < WORDS; i++)
      drive_word(words[16*i +: 16], (i == WORDS - 1) ? 7 : 16, (i == stall_word) ? stall_cycles : 0);
    do begin
      tick();
      #2;
      n++;
    end while (done_count == base_done && n < 400);
    checkOutput("done_seen", 128'(done_count - base_done), 128'(1));
    checkOutput("latency", 128'(t_done - t_start), 128'(exp_lat));
    checkOutput("busy_at_done", 128'(busy), 128'(1));
    checkOutput("se_at_done", 128'(se), 128'(0));
    tick();
    checkOutput("busy_after_done", 128'(busy), 128'(0));
    checkOutput("done_one_cycle", 128'(done), 128'(0));
    checkOutput("se_high_cycles", 128'(se_count - base_se), 128'(CHAIN_LEN));
    checkOutput("chain_contents", 128'(chain), 128'(words[CHAIN_LEN-1:0]));
    checkOutput("si_queue_drained", 128'(si_q.size()), 128'(0));
`ifdef SCAN_CHAIN_READBACK_EN
    checkOutput("rb_queue_drained", 128'(rb_q.size()), 128'(0));
`endif
  endtask

  initial begin
    int base_se, base_done, n;
    logic [79:0] rnd;

    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("reset_cfg_ready", 128'(cfg_ready), 128'(0));
    checkOutput("reset_se", 128'(se), 128'(0));
    checkOutput("reset_si", 128'(si), 128'(0));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    checkOutput("reset_done", 128'(done), 128'(0));

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    tick();
    checkOutput("abort_start_busy", 128'(busy), 128'(0));
    checkOutput("abort_start_ready", 128'(cfg_ready), 128'(0));

    applyStimulus({5{16'hFFFF}}, -1, 0, BASE_LAT);
    checkOutput("field_H", 128'(chain[70:63]), 128'(8'hFF));
    checkOutput("field_X", 128'(chain[0]), 128'(1));

    applyStimulus({64'h0, 16'h0001}, -1, 0, BASE_LAT);
    checkOutput("x_only_X", 128'(chain[0]), 128'(1));
    checkOutput("x_only_rest", 128'(chain[70:1]), 128'(0));

    applyStimulus({16'hFF80, 64'h0}, -1, 0, BASE_LAT);

    applyStimulus({16'h0F5A, 16'h3C3C, 16'hBEEF, 16'h1234, 16'hC001}, 1, 10, BASE_LAT + 10);

    // abort after 30 se-high cycles
    base_se   = se_count;
    base_done = done_count;
    pulse_start();
    drive_word(16'h1234, 16, 0);
    drive_word(16'h5678, 16, 0);
    n = 0;
    do begin
      tick();
      #2;
      n++;
    end while (se_count - base_se < 30 && n < 100);
    checkOutput("abort_point", 128'(se_count - base_se), 128'(30));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    tick();
    checkOutput("abort_busy", 128'(busy), 128'(0));
    checkOutput("abort_se", 128'(se), 128'(0));
    checkOutput("abort_ready", 128'(cfg_ready), 128'(0));
    checkOutput("abort_done", 128'(done), 128'(0));
    si_q.delete();
`ifdef SCAN_CHAIN_READBACK_EN
    rb_q.delete();
`endif
    repeat (5) tick();
    checkOutput("abort_no_done", 128'(done_count - base_done), 128'(0));

    rnd = {$urandom, $urandom, $urandom};
    applyStimulus(rnd, -1, 0, BASE_LAT);

`ifdef SCAN_CHAIN_READBACK_EN
    applyStimulus({5{16'hA5A5}}, -1, 0, BASE_LAT);
    checkOutput("rb_last_word_model", 128'({9'b0, chain[70:64]}), 128'(16'h0025));
    rb_stall_left = 5;
    applyStimulus({16'h0077, 16'h1111, 16'h2222, 16'h3333, 16'h4444}, -1, 0, BASE_LAT + 5);
    checkOutput("rb_stall_consumed", 128'(rb_stall_left), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
